// File: rtl/envelope_vca.sv
// rtl/envelope_vca.sv - envelope-controlled amplifier: SampleOut = (SampleIn * (Envolope + 1)) >> WAVE_DEPTH
// Sequential shift-add multiplier, one multiplier bit per clock, valid/ready on both sides.
module envelope_vca #(
    parameter int WAVE_DEPTH = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [WAVE_DEPTH-1:0] SampleIn,
    input  logic [WAVE_DEPTH-1:0] Envolope,
    input  logic                  InValid,
    output logic                  InReady,
    output logic [WAVE_DEPTH-1:0] SampleOut,
    output logic                  OutValid,
    input  logic                  OutReady
);

    localparam int ACC_W  = 2 * WAVE_DEPTH + 1;
    localparam int MPLR_W = WAVE_DEPTH + 1;
    localparam int CNT_W  = $clog2(WAVE_DEPTH + 2);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WAVE_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t                state, state_next;
    logic [ACC_W-1:0]      mcand, mcand_next;
    logic [MPLR_W-1:0]     mplr, mplr_next;
    logic [ACC_W-1:0]      acc, acc_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [WAVE_DEPTH-1:0] sample_next;
    logic [ACC_W-1:0]      acc_sum;
    logic                  accept;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            mcand     <= '0;
            mplr      <= '0;
            acc       <= '0;
            cnt       <= '0;
            SampleOut <= '0;
        end else begin
            state     <= state_next;
            mcand     <= mcand_next;
            mplr      <= mplr_next;
            acc       <= acc_next;
            cnt       <= cnt_next;
            SampleOut <= sample_next;
        end
    end

    // InReady sees OutReady combinationally so a result can hand off and reload in one cycle.
    assign InReady  = Reset && ((state == IDLE) || ((state == DONE) && OutReady));
    assign OutValid = (state == DONE);
    assign accept   = InValid && InReady;
    assign acc_sum  = acc + (mplr[0] ? mcand : '0);

    always_comb begin
        state_next  = state;
        mcand_next  = mcand;
        mplr_next   = mplr;
        acc_next    = acc;
        cnt_next    = cnt;
        sample_next = SampleOut;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = MUL;
                    mcand_next = {{(ACC_W - WAVE_DEPTH){1'b0}}, SampleIn};
                    mplr_next  = {1'b0, Envolope} + MPLR_W'(1);
                    acc_next   = '0;
                    cnt_next   = '0;
                end
            end
            MUL: begin
                acc_next   = acc_sum;
                mcand_next = mcand << 1;
                mplr_next  = mplr >> 1;
                cnt_next   = cnt + CNT_W'(1);
                // The final partial product is folded in on the same edge that leaves MUL.
                if (cnt == LAST_STEP) begin
                    state_next  = DONE;
                    sample_next = acc_sum[2*WAVE_DEPTH-1:WAVE_DEPTH];
                end
            end
            DONE: begin
                if (OutReady) begin
                    if (accept) begin
                        state_next = MUL;
                        mcand_next = {{(ACC_W - WAVE_DEPTH){1'b0}}, SampleIn};
                        mplr_next  = {1'b0, Envolope} + MPLR_W'(1);
                        acc_next   = '0;
                        cnt_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_envelope_vca.sv
// tb/tb_envelope_vca.sv - self-checking bench for envelope_vca
module tb_envelope_vca;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] SampleIn = 8'd0;
    logic [7:0] Envolope = 8'd0;
    logic       InValid = 1'b0;
    logic       OutReady = 1'b1;
    logic       InReady;
    logic       OutValid;
    logic [7:0] SampleOut;

    int checks = 0;
    int errors = 0;

    envelope_vca #(.WAVE_DEPTH(8)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .SampleIn (SampleIn),
        .Envolope (Envolope),
        .InValid  (InValid),
        .InReady  (InReady),
        .SampleOut(SampleOut),
        .OutValid (OutValid),
        .OutReady (OutReady)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int s;
        int e;
        int exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int ref_scale(input int s, input int e);
        return (s * (e + 1)) / 256;
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!InReady && guard < 50) begin
            step();
            guard++;
        end
    endtask

    // Launch one operation and return the result plus cycles from accept edge to OutValid.
    task automatic do_op(input int s, input int e, output int res, output int lat);
        wait_ready();
        SampleIn = 8'(s);
        Envolope = 8'(e);
        InValid  = 1'b1;
        step();
        InValid = 1'b0;
        lat = 0;
        while (!OutValid && lat < 50) begin
            step();
            lat++;
        end
        res = int'(SampleOut);
        if (OutReady) step();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int res, lat, s, e;
        int ps[16];
        int pe[16];
        int idx, nout, last, cyc;
        logic take;

        vecs[0] = '{200, 255, 200};
        vecs[1] = '{200, 127, 100};
        vecs[2] = '{255, 255, 255};
        vecs[3] = '{1,   255, 1};
        vecs[4] = '{255, 0,   0};
        vecs[5] = '{255, 1,   1};
        vecs[6] = '{0,   255, 0};
        vecs[7] = '{128, 128, 64};

        repeat (3) @(posedge Clock);
        #1;
        check("reset_inready", InReady, 0);
        check("reset_outvalid", OutValid, 0);
        check("reset_sampleout", SampleOut, 0);
        #2 Reset = 1'b1;
        #1 check("post_reset_inready", InReady, 1);

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].s, vecs[i].e, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, 9);
        end

        for (int i = 0; i < 1500; i++) begin
            s = $urandom_range(255, 0);
            e = (i % 10 == 0) ? 255 : (i % 10 == 1) ? 0 : $urandom_range(255, 0);
            do_op(s, e, res, lat);
            check($sformatf("rand_s%0d_e%0d", s, e), res, ref_scale(s, e));
        end

        // Back-to-back streaming: results every WAVE_DEPTH+2 cycles, in order.
        OutReady = 1'b1;
        wait_ready();
        for (int i = 0; i < 16; i++) begin
            ps[i] = $urandom_range(255, 0);
            pe[i] = $urandom_range(255, 0);
        end
        idx = 0; nout = 0; last = 0; cyc = 0;
        SampleIn = 8'(ps[0]);
        Envolope = 8'(pe[0]);
        InValid  = 1'b1;
        while (nout < 16 && cyc < 400) begin
            if (OutValid) begin
                check($sformatf("b2b_result%0d", nout), SampleOut, ref_scale(ps[nout], pe[nout]));
                check("b2b_inready_done", InReady, 1);
                if (nout > 0) check("b2b_spacing", cyc - last, 10);
                last = cyc;
                nout++;
            end
            take = InReady && InValid;
            step();
            cyc++;
            if (take) begin
                idx++;
                if (idx < 16) begin
                    SampleIn = 8'(ps[idx]);
                    Envolope = 8'(pe[idx]);
                end else begin
                    InValid = 1'b0;
                end
            end
        end
        InValid = 1'b0;
        check("b2b_count", nout, 16);
        step();

        // Back-pressure: result held while OutReady=0, new requests refused.
        wait_ready();
        OutReady = 1'b0;
        SampleIn = 8'd100;
        Envolope = 8'd255;
        InValid  = 1'b1;
        step();
        InValid = 1'b0;
        lat = 0;
        while (!OutValid && lat < 50) begin
            step();
            lat++;
        end
        check("bp_latency", lat, 9);
        for (int i = 0; i < 20; i++) begin
            if (i >= 5 && i < 10) begin
                SampleIn = 8'd7;
                Envolope = 8'd0;
                InValid  = 1'b1;
            end else begin
                InValid = 1'b0;
            end
            #1;
            check("bp_sampleout", SampleOut, 100);
            check("bp_outvalid", OutValid, 1);
            check("bp_inready", InReady, 0);
            step();
        end
        InValid  = 1'b0;
        OutReady = 1'b1;
        #1 check("bp_release_inready", InReady, 1);
        step();
        check("bp_after_outvalid", OutValid, 0);
        check("bp_after_inready", InReady, 1);
        step();
        step();
        check("bp_no_queued_op", InReady, 1);
        check("bp_hold_sampleout", SampleOut, 100);

        // Reset during MUL: asynchronous clear, no partial result.
        SampleIn = 8'd200;
        Envolope = 8'd200;
        InValid  = 1'b1;
        step();
        InValid = 1'b0;
        repeat (3) step();
        #2 Reset = 1'b0;
        #1;
        check("rst_mid_outvalid", OutValid, 0);
        check("rst_mid_sampleout", SampleOut, 0);
        check("rst_mid_inready", InReady, 0);
        repeat (2) step();
        check("rst_hold_outvalid", OutValid, 0);
        #2 Reset = 1'b1;
        #1;
        repeat (12) begin
            check("rst_no_ghost", OutValid, 0);
            step();
        end
        do_op(50, 255, res, lat);
        check("rst_after_result", res, 50);
        check("rst_after_latency", lat, 9);

        // Operand isolation: inputs wiggle during MUL with no effect.
        wait_ready();
        SampleIn = 8'd80;
        Envolope = 8'd255;
        InValid  = 1'b1;
        step();
        InValid = 1'b0;
        lat = 0;
        while (!OutValid && lat < 50) begin
            SampleIn = 8'($urandom_range(255, 0));
            Envolope = 8'($urandom_range(255, 0));
            step();
            lat++;
        end
        check("iso_result", SampleOut, 80);
        check("iso_latency", lat, 9);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
